voice_mix_buffer: RTL and testbench

Parametrised mixer and elastic buffer between the note generator and the audio/display consumers. Each generator strobe supplies CHANNELS signed voice samples; each enabled voice is attenuated by a per-channel right shift, and the voices are summed with saturation. The result is pushed into a DEPTH-entry FIFO. The FIFO is drained one word per codec frame strobe, which gives the codec headphone path and the display scope path a single registered sample/valid pair. This replaces the fixed single-voice, single-register sample hand-off with multi-voice mixing, rate decoupling and underrun/overflow reporting.

---
 rtl/voice_mix_buffer_if.sv | 35 +++
 rtl/voice_mix_buffer.sv | 142 ++++++++++++++
 tb/tb_voice_mix_buffer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/voice_mix_buffer_if.sv
// rtl/voice_mix_buffer_if.sv - generator/codec-side signal bundle for voice_mix_buffer
interface voice_mix_buffer_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int GAIN_W   = 3
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [CHANNELS*WIDTH-1:0]  in_samples;
  logic                       in_valid;
  logic [CHANNELS-1:0]        channel_enable;
  logic [CHANNELS*GAIN_W-1:0] attenuation;
  logic                       new_frame;
  logic                       clear_status;
  logic [WIDTH-1:0]           sample_out;
  logic                       sample_valid;
  logic [LW-1:0]              level;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       overflow;
  logic [15:0]                underrun_count;

  // Generator / codec / status side
  modport master (
    output in_samples, in_valid, channel_enable, attenuation, new_frame, clear_status,
    input  sample_out, sample_valid, level, fifo_full, fifo_empty, overflow, underrun_count
  );

  // Mixer / buffer side
  modport slave (
    input  in_samples, in_valid, channel_enable, attenuation, new_frame, clear_status,
    output sample_out, sample_valid, level, fifo_full, fifo_empty, overflow, underrun_count
  );
endinterface

// File: rtl/voice_mix_buffer.sv
// rtl/voice_mix_buffer.sv - multi-voice attenuate/saturating mixer feeding a frame-drained FIFO
module voice_mix_buffer #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int GAIN_W   = 3
) (
  input logic              clk,
  input logic              reset_n,
  voice_mix_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int SW = WIDTH + $clog2(CHANNELS) + 1;
  localparam logic signed [SW-1:0] MAX_V  = (SW'(1) <<< (WIDTH - 1)) - SW'(1);
  localparam logic signed [SW-1:0] MIN_V  = -(SW'(1) <<< (WIDTH - 1));
  localparam logic [LW-1:0]        FULL_L = LW'(DEPTH);
  localparam logic [15:0]          CNT_MAX = 16'hFFFF;

  logic signed [WIDTH-1:0] term_d [CHANNELS];
  logic signed [WIDTH-1:0] term_q [CHANNELS];
  logic                    s1_valid_q;
  logic signed [SW-1:0]    sum_d;
  logic [WIDTH-1:0]        word_d;
  logic [WIDTH-1:0]        word_q;
  logic                    s2_valid_q;

  logic [WIDTH-1:0]        mem [DEPTH];
  logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]           level_q, level_d;
  logic                    full_q, empty_q;
  logic                    pop_ok, push_ok, drop;
  logic [WIDTH-1:0]        sample_out_q;
  logic                    sample_valid_q;
  logic                    overflow_q;
  logic [15:0]             underrun_q;

  // Per-voice mute and arithmetic attenuation of the incoming samples
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      term_d[k] = '0;
      if (bus.channel_enable[k])
        term_d[k] = $signed(bus.in_samples[k*WIDTH +: WIDTH]) >>> bus.attenuation[k*GAIN_W +: GAIN_W];
    end
  end

  // Stage 1: capture attenuated terms only on a generator strobe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) term_q[k] <= '0;
    end else begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        for (int k = 0; k < CHANNELS; k++) term_q[k] <= term_d[k];
      end
    end
  end

  // Wide signed sum of all terms, clamped back to the sample range
  always_comb begin
    sum_d = '0;
    for (int k = 0; k < CHANNELS; k++) sum_d = sum_d + SW'(term_q[k]);
    word_d = sum_d[WIDTH-1:0];
    if (sum_d > MAX_V)      word_d = MAX_V[WIDTH-1:0];
    else if (sum_d < MIN_V) word_d = MIN_V[WIDTH-1:0];
  end

  // Stage 2: registered mixed word and its write request
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid_q <= 1'b0;
      word_q     <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) word_q <= word_d;
    end
  end

  // A pop only succeeds on stored words, so a same-cycle write never bypasses to the reader
  always_comb begin
    pop_ok  = bus.new_frame && !empty_q;
    push_ok = s2_valid_q && ((level_q != FULL_L) || pop_ok);
    drop    = s2_valid_q && !push_ok;
    level_d = level_q;
    if (push_ok && !pop_ok)      level_d = level_q + LW'(1);
    else if (pop_ok && !push_ok) level_d = level_q - LW'(1);
  end

  // FIFO storage; contents are meaningless while level says so, hence no reset
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= word_q;
  end

  // Pointers, occupancy flags and the registered output pair
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok) begin
        rd_ptr_q     <= rd_ptr_q + PW'(1);
        sample_out_q <= mem[rd_ptr_q];
      end
      sample_valid_q <= pop_ok;
      level_q        <= level_d;
      full_q         <= (level_d == FULL_L);
      empty_q        <= (level_d == '0);
    end
  end

  // Sticky status; a new event in the clearing cycle takes priority over the clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q <= 1'b0;
      underrun_q <= '0;
    end else begin
      if (drop)                   overflow_q <= 1'b1;
      else if (bus.clear_status)  overflow_q <= 1'b0;
      if (bus.new_frame && empty_q) begin
        if (bus.clear_status)          underrun_q <= 16'd1;
        else if (underrun_q != CNT_MAX) underrun_q <= underrun_q + 16'd1;
      end else if (bus.clear_status) begin
        underrun_q <= '0;
      end
    end
  end

  assign bus.sample_out     = sample_out_q;
  assign bus.sample_valid   = sample_valid_q;
  assign bus.level          = level_q;
  assign bus.fifo_full      = full_q;
  assign bus.fifo_empty     = empty_q;
  assign bus.overflow       = overflow_q;
  assign bus.underrun_count = underrun_q;
endmodule

// File: tb/tb_voice_mix_buffer.sv
// tb/tb_voice_mix_buffer.sv - directed self-checking bench for voice_mix_buffer
module tb_voice_mix_buffer;
  localparam int CH = 4;
  localparam int W  = 16;
  localparam int D  = 8;
  localparam int G  = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [15:0] exp_q [$];

  voice_mix_buffer_if #(.CHANNELS(CH), .WIDTH(W), .DEPTH(D), .GAIN_W(G)) vif ();

  voice_mix_buffer #(.CHANNELS(CH), .WIDTH(W), .DEPTH(D), .GAIN_W(G)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (vif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_mix(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                         input logic [15:0] d, input logic [3:0] en, input logic [11:0] att);
    vif.in_samples     = {d, c, b, a};
    vif.channel_enable = en;
    vif.attenuation    = att;
  endtask

  task automatic push_one;
    vif.in_valid = 1'b1;
    tick();
    vif.in_valid = 1'b0;
  endtask

  task automatic pop_one;
    vif.new_frame = 1'b1;
    tick();
    vif.new_frame = 1'b0;
  endtask

  task automatic mix_case(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [15:0] d, input logic [3:0] en,
                          input logic [11:0] att, input logic [15:0] exp);
    set_mix(a, b, c, d, en, att);
    push_one();
    tick();
    tick();
    pop_one();
    check(tag, vif.sample_out, exp);
    check({tag, "_valid"}, vif.sample_valid, 1);
  endtask

  initial begin
    logic [15:0] v;
    logic [15:0] e;
    int pushed;

    vif.in_samples     = '0;
    vif.in_valid       = 1'b0;
    vif.channel_enable = '0;
    vif.attenuation    = '0;
    vif.new_frame      = 1'b0;
    vif.clear_status   = 1'b0;

    // reset state
    tick();
    tick();
    check("rst_sample_out", vif.sample_out, 0);
    check("rst_valid", vif.sample_valid, 0);
    check("rst_level", vif.level, 0);
    check("rst_empty", vif.fifo_empty, 1);
    check("rst_full", vif.fifo_full, 0);
    check("rst_overflow", vif.overflow, 0);
    check("rst_underrun", vif.underrun_count, 0);
    reset_n = 1'b1;

    // reset mid-stream discards FIFO and pipeline contents
    set_mix(16'd5, 16'd0, 16'd0, 16'd0, 4'b0001, 12'd0);
    push_one();
    tick();
    tick();
    check("pre_rst_level", vif.level, 1);
    push_one();
    #2 reset_n = 1'b0;
    #1;
    check("midrst_level", vif.level, 0);
    check("midrst_empty", vif.fifo_empty, 1);
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    tick();
    check("rst_discard_level", vif.level, 0);

    // basic mix 100+200-50+10 = 260
    set_mix(16'd100, 16'd200, 16'hFFCE, 16'd10, 4'b1111, 12'd0);
    push_one();
    tick();
    check("level_t1", vif.level, 0);
    tick();
    check("level_t2", vif.level, 1);
    tick();
    tick();
    pop_one();
    check("basic_sample", vif.sample_out, 16'h0104);
    check("basic_valid", vif.sample_valid, 1);
    check("basic_level", vif.level, 0);
    check("basic_empty", vif.fifo_empty, 1);
    tick();
    check("basic_valid_pulse", vif.sample_valid, 0);

    // saturation and attenuation
    mix_case("sat_max", 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 4'b1111, 12'd0, 16'h7FFF);
    mix_case("sat_min", 16'h8000, 16'h8000, 16'h8000, 16'h8000, 4'b1111, 12'd0, 16'h8000);
    mix_case("shift2_ch0", 16'h8000, 16'h8000, 16'h8000, 16'h8000, 4'b0001, {9'd0, 3'd2}, 16'hE000);
    // 1024>>>1 + (-1024>>>3) + 300, channel 3 muted = 684
    mix_case("mixed_att", 16'd1024, 16'hFC00, 16'd300, 16'd77, 4'b0111,
             {3'd0, 3'd0, 3'd3, 3'd1}, 16'h02AC);

    // fill past full: words 1..8 kept, 9 and 10 dropped
    for (int i = 1; i <= 10; i++) begin
      set_mix(16'(i), 16'd0, 16'd0, 16'd0, 4'b0001, 12'd0);
      vif.in_valid = 1'b1;
      tick();
    end
    vif.in_valid = 1'b0;
    tick();
    tick();
    check("full_level", vif.level, 8);
    check("full_flag", vif.fifo_full, 1);
    check("full_empty", vif.fifo_empty, 0);
    check("full_overflow", vif.overflow, 1);
    vif.clear_status = 1'b1;
    tick();
    vif.clear_status = 1'b0;
    check("ovf_cleared", vif.overflow, 0);

    // push lands in the pop cycle while full
    set_mix(16'd99, 16'd0, 16'd0, 16'd0, 4'b0001, 12'd0);
    push_one();
    tick();
    vif.new_frame = 1'b1;
    tick();
    vif.new_frame = 1'b0;
    check("simul_sample", vif.sample_out, 1);
    check("simul_valid", vif.sample_valid, 1);
    check("simul_level", vif.level, 8);
    check("simul_full", vif.fifo_full, 1);
    tick();
    check("simul_overflow", vif.overflow, 0);
    for (int i = 2; i <= 9; i++) begin
      e = (i == 9) ? 16'd99 : 16'(i);
      pop_one();
      check($sformatf("order_%0d", i), vif.sample_out, e);
    end
    check("drained_level", vif.level, 0);
    check("drained_empty", vif.fifo_empty, 1);

    // underrun: three empty pops
    for (int i = 0; i < 3; i++) begin
      pop_one();
      check($sformatf("underrun_valid_%0d", i), vif.sample_valid, 0);
    end
    check("underrun_count3", vif.underrun_count, 3);
    check("underrun_hold", vif.sample_out, 16'd99);
    vif.clear_status = 1'b1;
    tick();
    vif.clear_status = 1'b0;
    check("underrun_cleared", vif.underrun_count, 0);
    vif.clear_status = 1'b1;
    vif.new_frame    = 1'b1;
    tick();
    vif.clear_status = 1'b0;
    vif.new_frame    = 1'b0;
    check("clear_vs_underrun", vif.underrun_count, 1);

    // pointer wrap: bursts of 3 pushes and 2 pops, 20 words total
    pushed = 0;
    while (pushed < 20) begin
      for (int b = 0; b < 3 && pushed < 20; b++) begin
        v = 16'(pushed * 3001 - 30000);
        set_mix(v, 16'd0, 16'd0, 16'd0, 4'b0001, 12'd0);
        vif.in_valid = 1'b1;
        exp_q.push_back(v);
        tick();
        pushed++;
      end
      vif.in_valid = 1'b0;
      tick();
      tick();
      for (int p = 0; p < 2; p++) begin
        pop_one();
        e = exp_q.pop_front();
        check("wrap_word", vif.sample_out, e);
      end
    end
    while (exp_q.size() > 0) begin
      pop_one();
      e = exp_q.pop_front();
      check("wrap_tail", vif.sample_out, e);
    end
    check("wrap_level", vif.level, 0);
    check("wrap_overflow", vif.overflow, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
